// File: rtl/service_pkg.sv
// ---------------------------------------------------------------------------
// service_pkg
// Definitions shared by the time-set, countdown and display stages.
//   - state_e         : countdown controller states
//   - digit layout    : 16-bit MMSS word, one BCD digit per nibble,
//                       {MM tens, MM units, SS tens, SS units}
//   - digit maxima    : largest legal value of each digit position
//   - mmss_sanitise() : saturates an arbitrary 16-bit word to a legal MM:SS
// ---------------------------------------------------------------------------
package service_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    RUN,
    PAUSE,
    DONE
  } state_e;

  localparam int DIG_W    = 4;
  localparam int SS_U_LSB = 0;
  localparam int SS_T_LSB = 4;
  localparam int MM_U_LSB = 8;
  localparam int MM_T_LSB = 12;

  localparam logic [3:0] DIG_MAX_UNITS   = 4'd9;
  localparam logic [3:0] DIG_MAX_MM_TENS = 4'd9;
  localparam logic [3:0] DIG_MAX_SS_TENS = 4'd5;

  function automatic logic [3:0] clamp_dig(input logic [3:0] d,
                                           input logic [3:0] mx);
    return (d > mx) ? mx : d;
  endfunction

  // A seconds field above 59 saturates to 59 as a whole, so an over-range
  // tens digit also pulls the units digit to 9 (0x0975 -> 0x0959).
  function automatic logic [15:0] mmss_sanitise(input logic [15:0] v);
    logic [15:0] r;
    r = v;
    r[MM_T_LSB +: DIG_W] = clamp_dig(v[MM_T_LSB +: DIG_W], DIG_MAX_MM_TENS);
    r[MM_U_LSB +: DIG_W] = clamp_dig(v[MM_U_LSB +: DIG_W], DIG_MAX_UNITS);
    r[SS_U_LSB +: DIG_W] = clamp_dig(v[SS_U_LSB +: DIG_W], DIG_MAX_UNITS);
    if (v[SS_T_LSB +: DIG_W] > DIG_MAX_SS_TENS) begin
      r[SS_T_LSB +: DIG_W] = DIG_MAX_SS_TENS;
      r[SS_U_LSB +: DIG_W] = DIG_MAX_UNITS;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_mmss_dec.sv
// ---------------------------------------------------------------------------
// bcd_mmss_dec
// Combinational one-second decrement of a BCD MM:SS word.
//   mmss_i          [15:0] current time {MM tens, MM units, SS tens, SS units}
//   mmss_o          [15:0] time minus one second (0000 stays 0000)
//   is_zero_next_o         mmss_o is 00:00
// Borrow chain: SS units 0->9, SS tens 0->5, MM units 0->9, MM tens -1.
// ---------------------------------------------------------------------------
module bcd_mmss_dec
  import service_pkg::*;
(
  input  logic [15:0] mmss_i,
  output logic [15:0] mmss_o,
  output logic        is_zero_next_o
);

  logic [3:0] d0, d1, d2, d3;
  logic [3:0] n0, n1, n2, n3;
  logic       b0, b1, b2;

  always_comb begin
    d0 = mmss_i[SS_U_LSB +: DIG_W];
    d1 = mmss_i[SS_T_LSB +: DIG_W];
    d2 = mmss_i[MM_U_LSB +: DIG_W];
    d3 = mmss_i[MM_T_LSB +: DIG_W];
    n0 = d0;
    n1 = d1;
    n2 = d2;
    n3 = d3;
    b0 = 1'b0;
    b1 = 1'b0;
    b2 = 1'b0;

    // 00:00 has nothing to borrow from; leave it untouched.
    if (mmss_i != 16'h0000) begin
      if (d0 == 4'd0) begin
        n0 = DIG_MAX_UNITS;
        b0 = 1'b1;
      end else begin
        n0 = d0 - 4'd1;
      end

      if (b0) begin
        if (d1 == 4'd0) begin
          n1 = DIG_MAX_SS_TENS;
          b1 = 1'b1;
        end else begin
          n1 = d1 - 4'd1;
        end
      end

      if (b1) begin
        if (d2 == 4'd0) begin
          n2 = DIG_MAX_UNITS;
          b2 = 1'b1;
        end else begin
          n2 = d2 - 4'd1;
        end
      end

      // A nonzero word that borrows this far always has MM tens > 0.
      if (b2) begin
        n3 = d3 - 4'd1;
      end
    end

    mmss_o         = {n3, n2, n1, n0};
    is_zero_next_o = (mmss_o == 16'h0000);
  end

endmodule

// File: rtl/service_2_countdown.sv
// ---------------------------------------------------------------------------
// service_2_countdown
// MM:SS countdown timer fed by the time-set stage.
//   clk      system clock
//   reset    asynchronous, active-high reset
//   finish1  set-complete level; its rising edge loads num_in
//   num_in   [15:0] BCD {MM tens, MM units, SS tens, SS units}
//   push_c   one-cycle debounced pulse, toggles start/pause
//   remain   [15:0] current BCD time, same layout as num_in
//   running  high while counting
//   done     high once 00:00 is reached, until push_c or a new load
//   alarm    toggles every second while done, 0 otherwise
// TICK_DIV clk cycles make one second.
// ---------------------------------------------------------------------------
module service_2_countdown
  import service_pkg::*;
#(
  parameter int unsigned TICK_DIV = 100_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        finish1,
  input  logic [15:0] num_in,
  input  logic        push_c,
  output logic [15:0] remain,
  output logic        running,
  output logic        done,
  output logic        alarm
);

  localparam int            PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  state_e        state_q, state_d;
  logic [15:0]   remain_q, remain_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          alarm_q, alarm_d;
  logic          running_q, done_q;
  logic          fin_d_q;

  logic          load;
  logic          tick;
  logic [15:0]   load_val;
  logic [15:0]   dec_val;
  logic          dec_zero;

  assign load     = finish1 & ~fin_d_q;
  assign load_val = mmss_sanitise(num_in);
  // The prescaler only advances in RUN and DONE, so tick cannot fire elsewhere.
  assign tick     = ((state_q == RUN) || (state_q == DONE)) && (presc_q == PRESC_MAX);

  bcd_mmss_dec u_dec (
    .mmss_i         (remain_q),
    .mmss_o         (dec_val),
    .is_zero_next_o (dec_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      remain_q  <= 16'h0000;
      presc_q   <= '0;
      alarm_q   <= 1'b0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      fin_d_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      remain_q  <= remain_d;
      presc_q   <= presc_d;
      alarm_q   <= alarm_d;
      running_q <= (state_d == RUN);
      done_q    <= (state_d == DONE);
      fin_d_q   <= finish1;
    end
  end

  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    alarm_d  = alarm_q;

    // A pause request freezes the prescaler in the same cycle, so resuming
    // picks up exactly where the count left off. A tick always wraps it.
    if (tick) begin
      presc_d = '0;
    end else if (((state_q == RUN) && !push_c) || (state_q == DONE)) begin
      presc_d = presc_q + 1'b1;
    end else begin
      presc_d = presc_q;
    end

    // A load edge outranks push_c everywhere it is honoured.
    if (load && (state_q != RUN)) begin
      state_d  = ARMED;
      remain_d = load_val;
      presc_d  = '0;
      alarm_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: ;
        ARMED: begin
          if (push_c) begin
            presc_d = '0;
            state_d = (remain_q != 16'h0000) ? RUN : DONE;
          end
        end
        RUN: begin
          if (tick) begin
            remain_d = dec_val;
          end
          // Reaching 00:00 wins over a simultaneous pause so PAUSE never
          // holds a zero time.
          if (tick && dec_zero) begin
            state_d = DONE;
          end else if (push_c) begin
            state_d = PAUSE;
          end
        end
        PAUSE: begin
          if (push_c) begin
            state_d = RUN;
          end
        end
        DONE: begin
          if (push_c) begin
            state_d  = IDLE;
            remain_d = 16'h0000;
            alarm_d  = 1'b0;
          end else if (tick) begin
            alarm_d = ~alarm_q;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign remain  = remain_q;
  assign running = running_q;
  assign done    = done_q;
  assign alarm   = alarm_q;

endmodule

// File: tb/tb_service_2_countdown.sv
// ---------------------------------------------------------------------------
// tb_service_2_countdown
// Directed scenarios followed by randomized stimulus, all checked every cycle
// against a reference model that tracks the remaining time in whole seconds.
// ---------------------------------------------------------------------------
module tb_service_2_countdown;

  localparam int TD = 4;

  localparam int M_IDLE  = 0;
  localparam int M_ARMED = 1;
  localparam int M_RUN   = 2;
  localparam int M_PAUSE = 3;
  localparam int M_DONE  = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        finish1;
  logic [15:0] num_in;
  logic        push_c;
  logic [15:0] remain;
  logic        running;
  logic        done;
  logic        alarm;

  always #5 clk = ~clk;

  service_2_countdown #(.TICK_DIV(TD)) dut (
    .clk     (clk),
    .reset   (reset),
    .finish1 (finish1),
    .num_in  (num_in),
    .push_c  (push_c),
    .remain  (remain),
    .running (running),
    .done    (done),
    .alarm   (alarm)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%04h expected 0x%04h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: time kept as seconds, prescaler as a phase count.
  int m_state, m_secs, m_ph, m_alarm, m_fprev;

  function automatic logic [15:0] to_bcd(input int s);
    int mm, ss;
    mm = s / 60;
    ss = s % 60;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  function automatic int sane_secs(input logic [15:0] n);
    logic [3:0] mt, mu, st, su;
    mt = (n[15:12] > 4'd9) ? 4'd9 : n[15:12];
    mu = (n[11:8]  > 4'd9) ? 4'd9 : n[11:8];
    st = n[7:4];
    su = (n[3:0]   > 4'd9) ? 4'd9 : n[3:0];
    if (st > 4'd5) begin
      st = 4'd5;
      su = 4'd9;
    end
    return (int'(mt) * 10 + int'(mu)) * 60 + int'(st) * 10 + int'(su);
  endfunction

  task automatic model_reset();
    m_state = M_IDLE;
    m_secs  = 0;
    m_ph    = 0;
    m_alarm = 0;
    m_fprev = 0;
  endtask

  task automatic model_step(input logic f, input logic [15:0] n, input logic p);
    bit ld, tk;
    ld = f && (m_fprev == 0);
    m_fprev = int'(f);
    tk = ((m_state == M_RUN) || (m_state == M_DONE)) && (m_ph == TD - 1);
    if (ld && m_state != M_RUN) begin
      m_state = M_ARMED;
      m_secs  = sane_secs(n);
      m_ph    = 0;
      m_alarm = 0;
    end else begin
      case (m_state)
        M_ARMED: if (p) begin
          m_ph    = 0;
          m_state = (m_secs != 0) ? M_RUN : M_DONE;
        end
        M_RUN: begin
          if (tk) begin
            m_secs = m_secs - 1;
            m_ph   = 0;
            if (m_secs == 0) m_state = M_DONE;
            else if (p)      m_state = M_PAUSE;
          end else if (p) begin
            m_state = M_PAUSE;
          end else begin
            m_ph = m_ph + 1;
          end
        end
        M_PAUSE: if (p) m_state = M_RUN;
        M_DONE: begin
          if (p) begin
            m_state = M_IDLE;
            m_secs  = 0;
            m_alarm = 0;
            m_ph    = 0;
          end else if (tk) begin
            m_alarm = 1 - m_alarm;
            m_ph    = 0;
          end else begin
            m_ph = m_ph + 1;
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic check_model();
    chk("remain",  remain,          to_bcd(m_secs));
    chk("running", {15'b0, running}, 16'(m_state == M_RUN));
    chk("done",    {15'b0, done},    16'(m_state == M_DONE));
    chk("alarm",   {15'b0, alarm},   16'(m_alarm));
  endtask

  // Inputs are applied 1 time unit after a rising edge and held for one cycle.
  task automatic cycle(input logic f, input logic [15:0] n, input logic p);
    finish1 = f;
    num_in  = n;
    push_c  = p;
    @(posedge clk);
    model_step(f, n, p);
    #1;
    check_model();
  endtask

  task automatic do_load(input logic [15:0] v);
    cycle(1'b0, v, 1'b0);
    cycle(1'b1, v, 1'b0);
  endtask

  // Asynchronous pulse placed between clock edges; outputs must clear at once.
  task automatic pulse_reset();
    #2 reset = 1'b1;
    model_reset();
    #1;
    chk("rst_remain",  remain,          16'h0000);
    chk("rst_running", {15'b0, running}, 16'h0000);
    chk("rst_done",    {15'b0, done},    16'h0000);
    chk("rst_alarm",   {15'b0, alarm},   16'h0000);
    #2 reset = 1'b0;
  endtask

  logic rf;

  initial begin
    reset   = 1'b1;
    finish1 = 1'b0;
    num_in  = 16'h0000;
    push_c  = 1'b0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    check_model();
    reset = 1'b0;

    // Load 00:12 and count down two seconds.
    do_load(16'h0012);
    chk("load_0012", remain, 16'h0012);
    cycle(1'b1, 16'h0012, 1'b1);
    repeat (4) cycle(1'b1, 16'h0012, 1'b0);
    chk("first_tick", remain, 16'h0011);
    chk("running_on", {15'b0, running}, 16'h0001);
    repeat (4) cycle(1'b1, 16'h0012, 1'b0);
    chk("second_tick", remain, 16'h0010);

    // Async reset while running from 01:30.
    pulse_reset();
    do_load(16'h0130);
    cycle(1'b1, 16'h0130, 1'b1);
    repeat (6) cycle(1'b1, 16'h0130, 1'b0);
    chk("pre_rst_remain", remain, 16'h0129);
    pulse_reset();

    // Full borrow chain 01:00 -> 00:59.
    do_load(16'h0100);
    cycle(1'b1, 16'h0100, 1'b1);
    repeat (4) cycle(1'b1, 16'h0100, 1'b0);
    chk("borrow_0059", remain, 16'h0059);
    pulse_reset();

    // Reach 00:00, alarm blinks, push returns to idle.
    do_load(16'h0002);
    cycle(1'b1, 16'h0002, 1'b1);
    repeat (8) cycle(1'b1, 16'h0002, 1'b0);
    chk("zero_remain", remain, 16'h0000);
    chk("zero_done", {15'b0, done}, 16'h0001);
    chk("zero_running", {15'b0, running}, 16'h0000);
    repeat (4) cycle(1'b1, 16'h0002, 1'b0);
    chk("alarm_hi", {15'b0, alarm}, 16'h0001);
    repeat (4) cycle(1'b1, 16'h0002, 1'b0);
    chk("alarm_lo", {15'b0, alarm}, 16'h0000);
    cycle(1'b1, 16'h0002, 1'b1);
    chk("idle_done", {15'b0, done}, 16'h0000);

    // Sanitising, then a zero load goes straight to DONE.
    do_load(16'h0975);
    chk("sanitise", remain, 16'h0959);
    do_load(16'h0000);
    cycle(1'b1, 16'h0000, 1'b1);
    chk("zero_start_done", {15'b0, done}, 16'h0001);
    chk("zero_start_run", {15'b0, running}, 16'h0000);

    // Pause at prescaler phase 2, resume two cycles from the next decrement.
    do_load(16'h0005);
    cycle(1'b1, 16'h0005, 1'b1);
    repeat (2) cycle(1'b1, 16'h0005, 1'b0);
    cycle(1'b1, 16'h0005, 1'b1);
    chk("paused", {15'b0, running}, 16'h0000);
    repeat (20) cycle(1'b1, 16'h0005, 1'b0);
    chk("frozen", remain, 16'h0005);
    cycle(1'b1, 16'h0005, 1'b1);
    chk("resumed", {15'b0, running}, 16'h0001);
    cycle(1'b1, 16'h0005, 1'b0);
    chk("resume_hold", remain, 16'h0005);
    cycle(1'b1, 16'h0005, 1'b0);
    chk("resume_tick", remain, 16'h0004);

    // Push and load together while paused: load wins.
    cycle(1'b1, 16'h0005, 1'b1);
    cycle(1'b0, 16'h0033, 1'b0);
    cycle(1'b1, 16'h0033, 1'b1);
    chk("conflict_val", remain, 16'h0033);
    chk("conflict_run", {15'b0, running}, 16'h0000);
    cycle(1'b1, 16'h0033, 1'b0);
    chk("conflict_armed", {15'b0, running}, 16'h0000);

    // Randomized traffic against the model.
    rf = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      logic [15:0] v;
      logic        p;
      if ($urandom_range(0, 15) == 0) rf = ~rf;
      if ($urandom_range(0, 3) == 0) v = 16'($urandom);
      else                           v = 16'($urandom_range(0, 21));
      p = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 599) == 0) pulse_reset();
      cycle(rf, v, p);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
